// File: rtl/bin_to_seg7_display_if.sv
// Value/load strobe from the counter side plus status and segment/anode outputs.
// The master side drives the value and the load strobe; the slave side is the display stage.
interface bin_to_seg7_display_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 4
);
  logic [N-1:0]      value;
  logic              load;
  logic              busy;
  logic              bcd_vld;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output value,
    output load,
    input  busy,
    input  bcd_vld,
    input  seg,
    input  an
  );

  modport slave (
    input  value,
    input  load,
    output busy,
    output bcd_vld,
    output seg,
    output an
  );
endinterface

// File: rtl/bin_to_seg7_display.sv
// bin_to_seg7_display: sequential double-dabble binary-to-BCD converter feeding a
// time-multiplexed, active-low 7-segment bank.
// Build option: define BIN_TO_SEG7_BLANK_LZ_EN to blank leading zero digits
// (digit 0 always shown). Overflow dashes win over blanking in both builds.
module bin_to_seg7_display #(
  parameter int unsigned N           = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  sys_clr,
  bin_to_seg7_display_if.slave  bus
);

  // Decimal digits needed to hold the largest N-bit value (N up to 63).
  function automatic int unsigned dec_digits(input int unsigned bits);
    longint unsigned m;
    int unsigned     d;
    m = (64'd1 << bits) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (m >= 64'd10) begin
        m = m / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 cannot reach here.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam int unsigned NeedDigits = dec_digits(N);
  // Accumulator is wide enough for the full value so overflow can be detected.
  localparam int unsigned AccDigits  = (NeedDigits > DIGITS) ? NeedDigits : DIGITS;
  localparam int unsigned AccW       = 4 * AccDigits;
  localparam int unsigned DispW      = 4 * DIGITS;
  localparam int unsigned CntW       = $clog2(N + 1);
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW       = $clog2(REFRESH_DIV);

  localparam logic [6:0] SegDark = 7'b1111111;
  localparam logic [6:0] SegDash = 7'b0111111;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      bin_q, bin_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [N-1:0]      pend_val_q, pend_val_d;
  logic              bcd_vld_q, bcd_vld_d;
  logic [DispW-1:0]  disp_q, disp_d;
  logic              disp_ovf_q, disp_ovf_d;

  logic [PreW-1:0]   pre_q, pre_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [AccW-1:0]   acc_adj;
  logic              acc_ovf;
  logic [3:0]        cur_nib;
  logic [6:0]        digit_seg;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(AccDigits); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Any non-zero nibble above the displayed digits means the value does not fit.
  always_comb begin
    acc_ovf = 1'b0;
    for (int i = int'(DIGITS); i < int'(AccDigits); i++) begin
      acc_ovf = acc_ovf | (acc_q[4*i +: 4] != 4'd0);
    end
  end

  // Conversion FSM next-state: capture, N shift steps, publish; queue loads seen while busy.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    bcd_vld_d  = 1'b0;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          bin_d   = bus.value;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
        end
        // Last load while busy wins.
        if (bus.load) begin
          pending_d  = 1'b1;
          pend_val_d = bus.value;
        end
      end
      StDone: begin
        disp_d     = acc_q[DispW-1:0];
        disp_ovf_d = acc_ovf;
        bcd_vld_d  = 1'b1;
        // A load on the DONE edge is newer than any queued value.
        if (bus.load || pending_q) begin
          bin_d     = bus.load ? bus.value : pend_val_q;
          acc_d     = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sys_clr) begin
      state_d    = StIdle;
      bin_d      = '0;
      acc_d      = '0;
      cnt_d      = '0;
      pending_d  = 1'b0;
      pend_val_d = '0;
      bcd_vld_d  = 1'b0;
      disp_d     = '0;
      disp_ovf_d = 1'b0;
    end
  end

  // Conversion state registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      pend_val_q <= '0;
      bcd_vld_q  <= 1'b0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pend_val_q <= pend_val_d;
      bcd_vld_q  <= bcd_vld_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

`ifdef BIN_TO_SEG7_BLANK_LZ_EN
  logic [IdxW-1:0] msd;

  // Segment pattern for the digit about to be lit, blanking zeros above the top digit.
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (disp_q[4*i +: 4] != 4'd0) begin
        msd = IdxW'(i);
      end
    end
    if (disp_ovf_q) begin
      digit_seg = SegDash;
    end else if (idx_q > msd) begin
      digit_seg = SegDark;
    end else begin
      digit_seg = dec7(cur_nib);
    end
  end
`else
  // Segment pattern for the digit about to be lit, zero-padded.
  always_comb begin
    if (disp_ovf_q) begin
      digit_seg = SegDash;
    end else begin
      digit_seg = dec7(cur_nib);
    end
  end
`endif

  // Scan next-state: idx_q names the digit lit at the next prescaler wrap.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (pre_q == PreW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = digit_seg;
    end
    if (sys_clr) begin
      pre_d = '0;
      idx_d = '0;
      an_d  = '1;
      seg_d = SegDark;
    end
  end

  // Scan registers; never stalled by conversion.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SegDark;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.bcd_vld = bcd_vld_q;
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;

endmodule

// File: tb/tb_bin_to_seg7_display.sv
// Bench for bin_to_seg7_display: table vectors, hand-written timing/pending/reset
// sequences, a 16-bit overflow instance, and random values against a decimal model.
module tb_bin_to_seg7_display;
  localparam int unsigned R  = 4;
  localparam int unsigned Nb = 8;

`ifdef BIN_TO_SEG7_BLANK_LZ_EN
  localparam bit LzEn = 1'b1;
`else
  localparam bit LzEn = 1'b0;
`endif

  logic sysclk  = 1'b0;
  logic reset_n = 1'b1;
  logic sys_clr = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 sysclk = ~sysclk;

  bin_to_seg7_display_if #(.N(8),  .DIGITS(4)) bm ();
  bin_to_seg7_display_if #(.N(16), .DIGITS(4)) bo ();

  bin_to_seg7_display #(.N(8), .DIGITS(4), .REFRESH_DIV(R)) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .sys_clr(sys_clr),
    .bus    (bm)
  );

  bin_to_seg7_display #(.N(16), .DIGITS(4), .REFRESH_DIV(R)) dut_o (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .sys_clr(sys_clr),
    .bus    (bo)
  );

  typedef struct {
    int value;
    int dig[4];
    int lead;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] dec_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: what digit i of a 4-digit display shows for value v.
  function automatic logic [6:0] seg_model(input int v, input int i);
    if (v > pow10(4) - 1) return 7'b0111111;
    if (LzEn && i > 0 && v < pow10(i)) return 7'b1111111;
    return dec_pat((v / pow10(i)) % 10);
  endfunction

  function automatic logic [3:0] cur_an(input bit sel);
    return sel ? bo.an : bm.an;
  endfunction

  function automatic logic [6:0] cur_seg(input bit sel);
    return sel ? bo.seg : bm.seg;
  endfunction

  function automatic logic cur_vld(input bit sel);
    return sel ? bo.bcd_vld : bm.bcd_vld;
  endfunction

  task automatic set_vec(input int i, input int v, input int d0, input int d1, input int d2,
                         input int d3, input int lead);
    vecs[i].value  = v;
    vecs[i].dig[0] = d0;
    vecs[i].dig[1] = d1;
    vecs[i].dig[2] = d2;
    vecs[i].dig[3] = d3;
    vecs[i].lead   = lead;
  endtask

  // Load strobe for one clock; returns just after the load edge.
  task automatic do_load(input bit sel, input int v);
    if (sel) begin
      bo.value = 16'(v);
      bo.load  = 1'b1;
    end else begin
      bm.value = 8'(v);
      bm.load  = 1'b1;
    end
    tick();
    bo.load = 1'b0;
    bm.load = 1'b0;
  endtask

  task automatic wait_vld(input bit sel, input string name, input int exp_lat);
    int cyc = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (cur_vld(sel)) begin
        cyc = t;
        break;
      end
    end
    chk({name, "_lat"}, cyc, exp_lat);
  endtask

  // Watch four digit slots and compare anode sequence and segments.
  task automatic scan_check(input bit sel, input string name, input logic [6:0] exp_seg[4]);
    logic [3:0] prev, cur, exp_an;
    int idx, prev_idx;
    prev     = cur_an(sel);
    prev_idx = -1;
    for (int w = 0; w < 4; w++) begin
      for (int t = 0; t < 2 * R + 2 && cur_an(sel) == prev; t++) tick();
      cur = cur_an(sel);
      idx = -1;
      for (int b = 0; b < 4; b++) begin
        exp_an = ~(4'b0001 << b);
        if (cur == exp_an) idx = b;
      end
      if (prev_idx < 0) begin
        chk({name, "_an_onehot"}, (idx >= 0), 1);
      end else begin
        exp_an = ~(4'b0001 << ((prev_idx + 1) % 4));
        chk({name, "_an_seq"}, cur, exp_an);
      end
      if (idx >= 0) chk({name, "_seg"}, cur_seg(sel), exp_seg[idx]);
      prev     = cur;
      prev_idx = idx;
    end
  endtask

  initial begin
    logic [6:0] e[4];
    logic [3:0] exp_an;
    int nvld, v;

    bm.value = '0;
    bm.load  = 1'b0;
    bo.value = '0;
    bo.load  = 1'b0;

    set_vec(0, 0,   0, 0, 0, 0, 1);
    set_vec(1, 42,  2, 4, 0, 0, 2);
    set_vec(2, 7,   7, 0, 0, 0, 1);
    set_vec(3, 99,  9, 9, 0, 0, 2);
    set_vec(4, 100, 0, 0, 1, 0, 3);
    set_vec(5, 10,  0, 1, 0, 0, 2);
    set_vec(6, 255, 5, 5, 2, 0, 3);
    set_vec(7, 208, 8, 0, 2, 0, 3);

    // Reset and check the dark idle state.
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", bm.busy, 0);
    chk("rst_vld", bm.bcd_vld, 0);
    chk("rst_an", bm.an, 4'hF);
    chk("rst_seg", bm.seg, 7'h7F);
    chk("rst_an_o", bo.an, 4'hF);
    reset_n = 1'b1;

    // First digit lights exactly R clocks after reset, then the anode walks up.
    for (int t = 1; t < int'(R); t++) tick();
    chk("scan_dark_before_wrap", bm.an, 4'hF);
    tick();
    chk("scan_first_an", bm.an, 4'b1110);
    chk("scan_first_seg", bm.seg, seg_model(0, 0));
    for (int d = 1; d < 4; d++) begin
      repeat (R) tick();
      exp_an = ~(4'b0001 << d);
      chk("scan_an", bm.an, exp_an);
      chk("scan_seg", bm.seg, seg_model(0, d));
    end

    // Load 255: busy through the shift steps, one bcd_vld pulse N+1 edges after load.
    do_load(0, 255);
    chk("t255_busy_k", bm.busy, 1);
    for (int c = 1; c <= int'(Nb) + 1; c++) begin
      tick();
      chk("t255_busy", bm.busy, (c <= int'(Nb)));
      chk("t255_vld", bm.bcd_vld, (c == int'(Nb) + 1));
    end
    tick();
    chk("t255_vld_pulse_end", bm.bcd_vld, 0);
    for (int i = 0; i < 4; i++) e[i] = seg_model(255, i);
    scan_check(0, "t255", e);

    // Table vectors.
    for (int k = 0; k < 8; k++) begin
      do_load(0, vecs[k].value);
      wait_vld(0, "vec", Nb + 1);
      for (int i = 0; i < 4; i++) begin
        e[i] = (LzEn && i >= vecs[k].lead) ? 7'b1111111 : dec_pat(vecs[k].dig[i]);
      end
      scan_check(0, "vec", e);
    end

    // Loads during SHIFT: last one (123) wins, two pulses, busy continuous.
    do_load(0, 7);
    for (int c = 1; c <= 2 * int'(Nb) + 2; c++) begin
      bm.load  = (c == 2 || c == 4);
      bm.value = (c == 2) ? 8'd200 : 8'd123;
      tick();
      bm.load = 1'b0;
      chk("pend_busy", bm.busy, (c < 2 * int'(Nb) + 2));
      chk("pend_vld", bm.bcd_vld, (c == int'(Nb) + 1 || c == 2 * int'(Nb) + 2));
    end
    for (int i = 0; i < 4; i++) e[i] = seg_model(123, i);
    scan_check(0, "pend", e);

    // Load on the DONE edge starts straight away.
    do_load(0, 42);
    for (int c = 1; c <= 2 * int'(Nb) + 2; c++) begin
      bm.load  = (c == int'(Nb) + 1);
      bm.value = 8'd9;
      tick();
      bm.load = 1'b0;
      chk("done_ld_busy", bm.busy, (c < 2 * int'(Nb) + 2));
      chk("done_ld_vld", bm.bcd_vld, (c == int'(Nb) + 1 || c == 2 * int'(Nb) + 2));
    end
    for (int i = 0; i < 4; i++) e[i] = seg_model(9, i);
    scan_check(0, "done_ld", e);

    // Async reset mid-shift aborts with no pulse; display returns to 0.
    do_load(0, 99);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_busy", bm.busy, 0);
    chk("abort_an", bm.an, 4'hF);
    tick();
    reset_n = 1'b1;
    nvld = 0;
    repeat (Nb + 4) begin
      tick();
      nvld += int'(bm.bcd_vld);
    end
    chk("abort_no_vld", nvld, 0);
    for (int i = 0; i < 4; i++) e[i] = seg_model(0, i);
    scan_check(0, "abort", e);

    // sys_clr on the DONE edge of 42 suppresses the update.
    do_load(0, 42);
    repeat (Nb) tick();
    sys_clr = 1'b1;
    tick();
    sys_clr = 1'b0;
    chk("clr_vld", bm.bcd_vld, 0);
    chk("clr_an", bm.an, 4'hF);
    chk("clr_busy", bm.busy, 0);
    scan_check(0, "clr", e);

    // Random values against the decimal model.
    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(255, 0));
      do_load(0, v);
      wait_vld(0, "rnd", Nb + 1);
      for (int i = 0; i < 4; i++) e[i] = seg_model(v, i);
      scan_check(0, "rnd", e);
    end

    // 16-bit instance: 10000 overflows four digits, 9999 just fits.
    do_load(1, 10000);
    wait_vld(1, "ovf", 17);
    for (int i = 0; i < 4; i++) e[i] = seg_model(10000, i);
    scan_check(1, "ovf", e);
    do_load(1, 9999);
    wait_vld(1, "fit", 17);
    for (int i = 0; i < 4; i++) e[i] = seg_model(9999, i);
    scan_check(1, "fit", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
